// File: rtl/color_detect_pkg.sv
// Shared types and constants for the color-detect pipeline.
// Hue width/limit, bbox FSM states and the bounding-box bundle.
package color_detect_pkg;

   localparam int HUE_W = 9;
   localparam logic [HUE_W-1:0] HUE_MAX = 9'd359;

   localparam int BB_XW = 10;
   localparam int BB_YW = 9;
   localparam int BB_CW = 19;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      REPORT
   } hue_bbox_state_t;

   typedef struct packed {
      logic [BB_XW-1:0] xmin;
      logic [BB_XW-1:0] xmax;
      logic [BB_YW-1:0] ymin;
      logic [BB_YW-1:0] ymax;
      logic [BB_CW-1:0] count;
   } bbox_t;

   // Empty box: min at all-ones so the first hit always wins.
   localparam bbox_t BBOX_INIT = '{
      xmin:  '1,
      xmax:  '0,
      ymin:  '1,
      ymax:  '0,
      count: '0
   };

endpackage

// File: rtl/hue_bbox_if.sv
// Pixel stream from hue_top into hue_bbox.
// One beat per cycle when valid; no backpressure.
interface hue_bbox_if;

   logic [15:0] data;
   logic        valid;
   logic        sof;
   logic        eol;
   logic        eof;

   modport master (
      output data, valid, sof, eol, eof
   );

   modport slave (
      input data, valid, sof, eol, eof
   );

endinterface

// File: rtl/hue_range_cmp.sv
// Combinational hue window test.
// Window is inclusive and wraps through 0 when lo > hi.
module hue_range_cmp
   import color_detect_pkg::*;
(
   input  logic [HUE_W-1:0] hue,
   input  logic [HUE_W-1:0] lo,
   input  logic [HUE_W-1:0] hi,
   output logic             hit
);

   logic in_deg;
   logic above_lo;
   logic below_hi;

   // Out-of-range hues never match, whatever the window.
   always_comb begin
      in_deg   = (hue <= HUE_MAX);
      above_lo = (hue >= lo);
      below_hi = (hue <= hi);
      hit      = 1'b0;
      if (in_deg) begin
         if (lo <= hi) hit = above_lo & below_hi;
         else          hit = above_lo | below_hi;
      end
   end

endmodule

// File: rtl/hue_bbox.sv
// Hue window mask plus per-frame bounding box and match count.
// Mask has 1-cycle latency; result strobes 2 cycles after eof.
module hue_bbox
   import color_detect_pkg::*;
#(
   parameter int IMG_W     = 640,
   parameter int IMG_H     = 480,
   parameter int XW        = BB_XW,
   parameter int YW        = BB_YW,
   parameter int CW        = BB_CW,
   parameter int MIN_COUNT = 16
)(
   input  logic             i_clk,
   input  logic             i_rst,
   hue_bbox_if.slave        pix,
   input  logic [HUE_W-1:0] i_hue_lo,
   input  logic [HUE_W-1:0] i_hue_hi,
   output logic             o_mask,
   output logic             o_mask_valid,
   output logic             o_bbox_valid,
   output logic             o_found,
   output logic [XW-1:0]    o_xmin,
   output logic [XW-1:0]    o_xmax,
   output logic [YW-1:0]    o_ymin,
   output logic [YW-1:0]    o_ymax,
   output logic [CW-1:0]    o_count,
   output logic             o_err
);

   localparam logic [XW-1:0] XLAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] YLAST = YW'(IMG_H - 1);

   hue_bbox_state_t state, state_nx;

   logic [HUE_W-1:0] hue;
   logic [HUE_W-1:0] lat_lo, lat_hi;
   logic             live_hit, lat_hit, hit;
   logic             sof_beat, eol_beat, eof_beat;
   logic             accum, ovf, found;

   logic [XW-1:0] x, x_nx, cur_x;
   logic [YW-1:0] y, y_nx, cur_y;
   bbox_t         acc, acc_nx, base, res;

   assign hue      = pix.data[HUE_W-1:0];
   assign sof_beat = pix.valid & pix.sof;
   assign eof_beat = pix.valid & pix.eof;
   assign eol_beat = pix.valid & (pix.eol | pix.eof);

   hue_range_cmp u_live (
      .hue (hue),
      .lo  (i_hue_lo),
      .hi  (i_hue_hi),
      .hit (live_hit)
   );

   hue_range_cmp u_lat (
      .hue (hue),
      .lo  (lat_lo),
      .hi  (lat_hi),
      .hit (lat_hit)
   );

   // The sof beat sees the window it is about to latch.
   assign hit   = pix.valid & (sof_beat ? live_hit : lat_hit);
   assign found = (acc.count >= CW'(MIN_COUNT));

   // Next state; a sof always (re)starts accumulation.
   always_comb begin
      state_nx = state;
      accum    = 1'b0;
      case (state)
         IDLE, REPORT: begin
            state_nx = IDLE;
            if (sof_beat) begin
               accum    = 1'b1;
               state_nx = eof_beat ? REPORT : ACTIVE;
            end
         end
         ACTIVE: begin
            accum = pix.valid;
            if (eof_beat) state_nx = REPORT;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Coordinate and accumulator update for the current beat.
   always_comb begin
      cur_x  = sof_beat ? '0 : x;
      cur_y  = sof_beat ? '0 : y;
      base   = sof_beat ? BBOX_INIT : acc;
      acc_nx = base;
      if (hit) begin
         if (cur_x < base.xmin) acc_nx.xmin = cur_x;
         if (cur_x > base.xmax) acc_nx.xmax = cur_x;
         if (cur_y < base.ymin) acc_nx.ymin = cur_y;
         if (cur_y > base.ymax) acc_nx.ymax = cur_y;
         if (base.count != '1) begin
            acc_nx.count = base.count + 1'b1;
         end
      end
      x_nx = cur_x + 1'b1;
      y_nx = cur_y;
      ovf  = 1'b0;
      if (eol_beat) begin
         x_nx = '0;
         if (!eof_beat) begin
            if (cur_y == YLAST) ovf  = 1'b1;
            else                y_nx = cur_y + 1'b1;
         end
      end else if (cur_x == XLAST) begin
         x_nx = XLAST;
         ovf  = 1'b1;
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nx;
   end

   // Mask path runs on every valid beat regardless of state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_mask       <= 1'b0;
         o_mask_valid <= 1'b0;
      end else begin
         o_mask       <= hit;
         o_mask_valid <= pix.valid;
      end
   end

   // Window is frozen for the frame at its sof beat.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         lat_lo <= '0;
         lat_hi <= '0;
      end else if (sof_beat) begin
         lat_lo <= i_hue_lo;
         lat_hi <= i_hue_hi;
      end
   end

   // Position counters and box accumulators.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         x   <= '0;
         y   <= '0;
         acc <= '0;
      end else if (accum) begin
         x   <= x_nx;
         y   <= y_nx;
         acc <= acc_nx;
      end
   end

   // Sticky framing error: restart mid-frame or counter overrun.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_err <= 1'b0;
      end else if ((state == ACTIVE && sof_beat) ||
                   (accum && ovf)) begin
         o_err <= 1'b1;
      end
   end

   // Result load; outputs hold until the next report.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_bbox_valid <= 1'b0;
         o_found      <= 1'b0;
         res          <= '0;
      end else begin
         o_bbox_valid <= (state == REPORT);
         if (state == REPORT) begin
            o_found <= found;
            res     <= found ? acc : bbox_t'{
               xmin:  '0,
               xmax:  '0,
               ymin:  '0,
               ymax:  '0,
               count: acc.count
            };
         end
      end
   end

   assign o_xmin  = res.xmin;
   assign o_xmax  = res.xmax;
   assign o_ymin  = res.ymin;
   assign o_ymax  = res.ymax;
   assign o_count = res.count;

endmodule

// File: tb/tb_hue_bbox.sv
// Self-checking bench for hue_bbox on a 4x4 image.
// Reference box/count computed from per-pixel positions.
module tb_hue_bbox;

   localparam int W    = 4;
   localparam int H    = 4;
   localparam int MINC = 2;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [8:0]  i_hue_lo, i_hue_hi;
   logic        o_mask, o_mask_valid, o_bbox_valid, o_found, o_err;
   logic [9:0]  o_xmin, o_xmax;
   logic [8:0]  o_ymin, o_ymax;
   logic [18:0] o_count;

   hue_bbox_if pix();

   hue_bbox #(
      .IMG_W     (W),
      .IMG_H     (H),
      .MIN_COUNT (MINC)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .pix          (pix),
      .i_hue_lo     (i_hue_lo),
      .i_hue_hi     (i_hue_hi),
      .o_mask       (o_mask),
      .o_mask_valid (o_mask_valid),
      .o_bbox_valid (o_bbox_valid),
      .o_found      (o_found),
      .o_xmin       (o_xmin),
      .o_xmax       (o_xmax),
      .o_ymin       (o_ymin),
      .o_ymax       (o_ymax),
      .o_count      (o_count),
      .o_err        (o_err)
   );

   always #5 i_clk = ~i_clk;

   int checks   = 0;
   int failures = 0;
   int strobes  = 0;
   int fh[16];

   // Count result strobes across the whole run.
   always @(negedge i_clk) if (o_bbox_valid === 1'b1) strobes++;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Hit iff the clockwise distance from lo reaches hue within the span.
   function automatic bit model_hit(int hue, int lo, int hi);
      int d, span;
      if (hue > 359) return 1'b0;
      d    = (hue - lo + 360) % 360;
      span = (hi - lo + 360) % 360;
      return d <= span;
   endfunction

   task automatic idle_inputs();
      pix.valid = 1'b0;
      pix.sof   = 1'b0;
      pix.eol   = 1'b0;
      pix.eof   = 1'b0;
   endtask

   task automatic beat(input int hue, input bit sof, input bit eol,
                       input bit eof, input bit m, input string tag);
      pix.data  = {7'($urandom_range(0, 127)), 9'(hue)};
      pix.valid = 1'b1;
      pix.sof   = sof;
      pix.eol   = eol;
      pix.eof   = eof;
      @(posedge i_clk);
      #1;
      chk({tag, ":mask_valid"}, o_mask_valid, 1);
      chk({tag, ":mask"}, o_mask, m);
      idle_inputs();
   endtask

   task automatic zero_check(input string tag);
      chk({tag, ":mask"}, o_mask, 0);
      chk({tag, ":mask_valid"}, o_mask_valid, 0);
      chk({tag, ":bbox_valid"}, o_bbox_valid, 0);
      chk({tag, ":found"}, o_found, 0);
      chk({tag, ":xmin"}, o_xmin, 0);
      chk({tag, ":xmax"}, o_xmax, 0);
      chk({tag, ":ymin"}, o_ymin, 0);
      chk({tag, ":ymax"}, o_ymax, 0);
      chk({tag, ":count"}, o_count, 0);
      chk({tag, ":err"}, o_err, 0);
   endtask

   task automatic do_reset(input string tag);
      idle_inputs();
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      zero_check(tag);
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   // Drive an n-pixel frame from fh[] and check the report.
   task automatic frame(input int n, input int lo, input int hi,
                        input int chg_at, input int nlo, input int nhi,
                        input string tag);
      int xmin, xmax, ymin, ymax, cnt, s0, x, y;
      bit m, fnd;
      xmin = 9999; xmax = -1; ymin = 9999; ymax = -1; cnt = 0;
      s0 = strobes;
      i_hue_lo = 9'(lo);
      i_hue_hi = 9'(hi);
      for (int i = 0; i < n; i++) begin
         if (i == chg_at) begin
            i_hue_lo = 9'(nlo);
            i_hue_hi = 9'(nhi);
         end
         x = i % W;
         y = i / W;
         m = model_hit(fh[i], lo, hi);
         if (m) begin
            cnt++;
            if (x < xmin) xmin = x;
            if (x > xmax) xmax = x;
            if (y < ymin) ymin = y;
            if (y > ymax) ymax = y;
         end
         beat(fh[i], i == 0, (x == W - 1) || (i == n - 1),
              i == n - 1, m, tag);
         if (i < n - 1 && $urandom_range(0, 3) == 0) begin
            @(posedge i_clk);
            #1;
            chk({tag, ":idle_mask_valid"}, o_mask_valid, 0);
         end
      end
      chk({tag, ":strobe_early"}, o_bbox_valid, 0);
      @(posedge i_clk);
      #1;
      fnd = (cnt >= MINC);
      chk({tag, ":strobe"}, o_bbox_valid, 1);
      chk({tag, ":found"}, o_found, fnd);
      chk({tag, ":xmin"}, o_xmin, fnd ? xmin : 0);
      chk({tag, ":xmax"}, o_xmax, fnd ? xmax : 0);
      chk({tag, ":ymin"}, o_ymin, fnd ? ymin : 0);
      chk({tag, ":ymax"}, o_ymax, fnd ? ymax : 0);
      chk({tag, ":count"}, o_count, cnt);
      @(posedge i_clk);
      #1;
      chk({tag, ":strobe_drop"}, o_bbox_valid, 0);
      chk({tag, ":count_hold"}, o_count, cnt);
      chk({tag, ":strobe_count"}, strobes - s0, 1);
   endtask

   initial begin
      int s0, lo, hi;
      pix.data = '0;
      i_hue_lo = '0;
      i_hue_hi = '0;
      i_rst    = 1'b0;
      idle_inputs();
      #2;
      do_reset("reset");

      // Three hits at (1,1), (2,1), (1,2).
      foreach (fh[i]) fh[i] = 0;
      fh[5] = 120; fh[6] = 120; fh[9] = 120;
      frame(16, 100, 140, -1, 0, 0, "basic");

      // Wrap window through 0.
      foreach (fh[i]) fh[i] = $urandom_range(200, 300);
      fh[0] = 350; fh[1] = 0; fh[2] = 20; fh[3] = 21; fh[4] = 339;
      frame(16, 340, 20, -1, 0, 0, "wrap");

      // No hits.
      foreach (fh[i]) fh[i] = 200;
      frame(16, 100, 140, -1, 0, 0, "nohit");

      // Mid-frame window change, then the new window applies.
      foreach (fh[i]) fh[i] = 0;
      fh[5] = 120; fh[6] = 120; fh[9] = 120;
      frame(16, 100, 140, 7, 0, 10, "midchg");
      frame(16, 0, 10, -1, 0, 0, "newwin");
      chk("no_err_yet", o_err, 0);

      // Single-pixel frame.
      fh[0] = 5;
      frame(1, 0, 10, -1, 0, 0, "single");

      // Second sof at (2,3) abandons the first frame.
      foreach (fh[i]) fh[i] = (i % 3 == 0) ? 120 : 30;
      s0 = strobes;
      i_hue_lo = 9'd100;
      i_hue_hi = 9'd140;
      for (int i = 0; i < 14; i++) begin
         beat(fh[i], i == 0, (i % W) == W - 1, 1'b0,
              model_hit(fh[i], 100, 140), "abandon");
      end
      foreach (fh[i]) fh[i] = (i % 5 == 1) ? 110 : 300;
      frame(16, 100, 140, -1, 0, 0, "restart");
      chk("restart:err", o_err, 1);
      chk("restart:one_strobe", strobes - s0, 1);

      // Reset mid-frame, then a clean frame.
      s0 = strobes;
      for (int i = 0; i < 6; i++) begin
         beat(fh[i], i == 0, (i % W) == W - 1, 1'b0,
              model_hit(fh[i], 100, 140), "prereset");
      end
      do_reset("midreset");
      chk("midreset:no_strobe", strobes - s0, 0);
      frame(16, 100, 140, -1, 0, 0, "clean");
      chk("clean:err", o_err, 0);

      // Randomized windows and hues.
      for (int r = 0; r < 6; r++) begin
         lo = $urandom_range(0, 359);
         hi = $urandom_range(0, 359);
         foreach (fh[i]) begin
            if ($urandom_range(0, 1) == 1)
               fh[i] = (lo + $urandom_range(0, 40)) % 360;
            else
               fh[i] = $urandom_range(0, 511);
         end
         frame(16, lo, hi, -1, 0, 0, "random");
      end

      // x overrun without eol.
      do_reset("rst_x");
      i_hue_lo = 9'd100;
      i_hue_hi = 9'd140;
      for (int i = 0; i < 3; i++) beat(500, i == 0, 0, 0, 0, "xrun");
      chk("xrun:err_before", o_err, 0);
      beat(500, 0, 0, 0, 0, "xrun");
      chk("xrun:err_after", o_err, 1);

      // y overrun without eof.
      do_reset("rst_y");
      for (int i = 0; i < 15; i++) begin
         beat(500, i == 0, (i % W) == W - 1, 0, 0, "yrun");
      end
      chk("yrun:err_before", o_err, 0);
      beat(500, 0, 1, 0, 0, "yrun");
      chk("yrun:err_after", o_err, 1);

      // eof while idle is ignored.
      do_reset("rst_eof");
      s0 = strobes;
      beat(500, 0, 1, 1, 0, "idle_eof");
      repeat (3) @(posedge i_clk);
      #1;
      chk("idle_eof:no_strobe", strobes - s0, 0);
      chk("idle_eof:err", o_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hue_bbox.md
Name: hue_bbox

Overview:
- Sits directly downstream of hue_top in the color-detect pipeline and consumes its 16-bit hue stream.
- Classifies each pixel as in-range or out-of-range against a programmable hue window, which may wrap through 0.
- Emits a per-pixel binary mask and, at end of frame, a bounding box and a match count for the matching pixels.
- The result feeds the overlay/tracking logic.

Parameters:
- IMG_W, 640, active pixels per line; x counter range 0..IMG_W-1.
- IMG_H, 480, active lines per frame; y counter range 0..IMG_H-1.
- XW, 10, x coordinate width; must satisfy 2^XW >= IMG_W.
- YW, 9, y coordinate width; must satisfy 2^YW >= IMG_H.
- CW, 19, match-count width; saturates at 2^CW-1.
- MIN_COUNT, 16, minimum match count for a frame to report found.

Ports:
- i_clk  in  1  pipeline clock
- i_rst  in  1  asynchronous active-high reset
- i_data  in  16  hue_top output; [8:0] hue in degrees 0..359; [15:9] ignored
- i_valid  in  1  pixel beat qualifier
- i_sof  in  1  with i_valid, marks first pixel of frame
- i_eol  in  1  with i_valid, marks last pixel of line
- i_eof  in  1  with i_valid, marks last pixel of frame (implies eol)
- i_hue_lo  in  9  window lower bound, inclusive
- i_hue_hi  in  9  window upper bound, inclusive
- o_mask  out  1  1 = pixel in window
- o_mask_valid  out  1  registered copy of i_valid
- o_bbox_valid  out  1  single-cycle result strobe
- o_found  out  1  count >= MIN_COUNT
- o_xmin, o_xmax  out  XW  bounding box columns
- o_ymin, o_ymax  out  YW  bounding box rows
- o_count  out  CW  matching pixels in frame
- o_err  out  1  sticky framing error

Behaviour:
- Reset: every output is 0. State goes to IDLE. Counters are 0. o_err is cleared only by reset.
- In-range rule:
  - lo <= hi: hit = lo <= hue <= hi.
  - lo > hi (wrap): hit = hue >= lo OR hue <= hi.
  - A hue > 359 is never a hit.
- Mask path: o_mask and o_mask_valid are registered, latency 1 cycle. Every valid beat produces a mask beat, in every state.
- FSM states:
  - IDLE: valid beats are ignored for accumulation. i_valid & i_sof -> ACTIVE.
  - ACTIVE: accumulate. i_valid & i_eof -> REPORT.
  - REPORT: one cycle. Load the outputs, pulse o_bbox_valid, return to IDLE.
- Result timing: o_bbox_valid rises 2 cycles after the eof beat (eof beat at cycle N, strobe at N+2).
- Window latch: i_hue_lo and i_hue_hi are sampled on the sof beat and held for the whole frame. Changes mid-frame take effect at the next sof. The mask path uses the latched window, except on the sof beat itself, which uses the live inputs.
- Counters:
  - The sof beat loads x=1 and y=0 and processes the pixel at (0,0).
  - Each valid beat increments x.
  - An eol beat sets x=0 and increments y.
- Accumulators:
  - Reset at sof to xmin=all-ones, xmax=0, ymin=all-ones, ymax=0, count=0. The sof pixel itself is then accumulated.
  - On a hit, update min/max. Count increments and saturates at 2^CW-1.
- Report contents:
  - found = count >= MIN_COUNT.
  - If not found: coordinate outputs are 0; o_count still shows the real count.
  - Outputs hold until the next REPORT.
- Boundaries and error cases:
  - Single-pixel frame (sof & eof on the same beat): ACTIVE lasts 0 cycles and goes straight to REPORT, which still works.
  - sof while ACTIVE: abandon the frame, set o_err, restart accumulation, no report.
  - x reaches IMG_W without eol: x saturates at IMG_W-1 and o_err sets.
  - y reaches IMG_H without eof: y saturates and o_err sets.
  - eof while IDLE: ignored, o_err unchanged.
  - Reset mid-frame: everything clears and no strobe is emitted.
- Throughput: one pixel per cycle, no backpressure.

Decomposition:
- color_detect_pkg holds:
  - HUE_W=9 and HUE_MAX=359;
  - the enum hue_bbox_state_t {IDLE, ACTIVE, REPORT};
  - the packed struct bbox_t {xmin, xmax, ymin, ymax, count}.
- Sub-module hue_range_cmp: combinational, inputs hue/lo/hi, output hit. The same sub-module is instanced for both the live window and the latched window.

Test Plan:
- Window 100..140, 4x4 frame, hues of 120 at (1,1), (2,1), (1,2), MIN_COUNT=2 -> mask beats 1 cycle after each input; strobe 2 cycles after eof; xmin=1, xmax=2, ymin=1, ymax=2, count=3, found=1.
- Wrap window lo=340, hi=20; hues 350, 0, 20, 21, 339 -> mask 1,1,1,0,0.
- No hits, 4x4 frame -> strobe with found=0, coordinates 0, count=0.
- Window changed from 100..140 to 0..10 mid-frame -> current frame's result is unaffected; new window applies after the next sof.
- Second sof injected at (2,3), then a full frame -> o_err=1; one strobe only, for the second frame, with correct box.
- Reset asserted mid-frame then a clean frame -> no spurious strobe; the clean frame reports correctly; o_err=0.
